// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
//   Sequencer and scan controller for a 4-digit common-anode seven-segment
//   display. It periodically samples a 14-bit binary value and asks an
//   external multi-cycle binary-to-BCD converter to convert it, using a
//   start/done handshake. It latches the four returned BCD digits and
//   time-multiplexes them onto the display. Leading-zero blanking is
//   optional. Inputs above 9999 show dashes on every digit, and a converter
//   that never answers raises a sticky error flag.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   d_in       : binary value to display (14 bits)
//   blank_en   : 1 = blank leading zeros
//   conv_start : one-cycle conversion request pulse to the converter
//   conv_din   : value presented to the converter, held from one request to the next
//   conv_done  : converter result valid (single-cycle or level)
//   bcd_in     : converter result, [15:12] thousands ... [3:0] ones
//   an         : digit enables, active-low, an[0] = ones digit
//   seg        : cathodes {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low, always off
//   err        : sticky converter-timeout flag, cleared by the next good conversion
module seg_display_ctrl #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int UPDATE_SCANS = 16,
  parameter int CONV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] d_in,
  input  logic        blank_en,
  output logic        conv_start,
  output logic [13:0] conv_din,
  input  logic        conv_done,
  input  logic [15:0] bcd_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        err
);

  localparam int PW = $clog2(DIGIT_CYCLES);
  localparam int SW = (UPDATE_SCANS > 1) ? $clog2(UPDATE_SCANS) : 1;
  localparam int TW = $clog2(CONV_TIMEOUT);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(UPDATE_SCANS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(CONV_TIMEOUT - 1);

  localparam logic [13:0] MAX_DISP = 14'd9999;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // BCD nibble to active-low segment pattern; non-decimal nibbles go blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;

  logic [PW-1:0]   r_presc;
  logic [1:0]      r_idx;
  logic [SW-1:0]   r_scan;
  logic            r_pend;
  logic [TW-1:0]   r_tcnt;
  logic [15:0]     r_disp;
  logic            r_ovf;
  logic            r_err;
  logic            r_conv_start;
  logic [13:0]     r_conv_din;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;

  logic            w_tick;
  logic            w_wrap;
  logic            w_req_evt;
  logic            w_start;
  logic            w_latch;
  logic            w_tmo;
  logic            w_ovf_set;
  logic [3:0]      w_nib;
  logic            w_lz;
  logic [6:0]      w_seg_nxt;

  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_wrap    = w_tick && (r_idx == 2'd3);
  assign w_req_evt = w_wrap && (r_scan == SCAN_LAST);

  // Scan timing: prescaler, digit index and scan counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_scan  <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= r_idx + 2'd1;
      if (w_wrap) r_scan <= (r_scan == SCAN_LAST) ? '0 : r_scan + 1'b1;
    end
  end

  // A request arriving in the same cycle the FSM leaves IDLE is kept, so it
  // is served by a later conversion rather than lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b1;
    end else if (w_req_evt) begin
      r_pend <= 1'b1;
    end else if (r_state == S_IDLE && w_state_nxt != S_IDLE) begin
      r_pend <= 1'b0;
    end
  end

  // Conversion sequencer: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Conversion sequencer: next state and per-cycle actions
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_latch     = 1'b0;
    w_tmo       = 1'b0;
    w_ovf_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (d_in > MAX_DISP) begin
          w_ovf_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // done has priority over a coincident timeout
        if (conv_done) begin
          w_latch     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_tcnt == TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs, timeout counter and latched result.
  // conv_start and conv_din are registered together, so the converter sees
  // the new operand in the same cycle as the request pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_start <= 1'b0;
      r_conv_din   <= '0;
      r_tcnt       <= '0;
      r_disp       <= '0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_conv_start <= w_start;
      if (w_start) begin
        r_conv_din <= d_in;
        r_tcnt     <= '0;
      end else if (r_state == S_WAIT) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_latch) begin
        r_disp <= bcd_in;
        r_ovf  <= 1'b0;
        r_err  <= 1'b0;
      end else if (w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  // Digit select: a digit counts as a leading zero when it and every
  // higher digit are zero; the ones digit never qualifies.
  always_comb begin
    w_nib = r_disp[3:0];
    w_lz  = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib = r_disp[3:0];
        w_lz  = 1'b0;
      end
      2'd1: begin
        w_nib = r_disp[7:4];
        w_lz  = (r_disp[15:4] == 12'd0);
      end
      2'd2: begin
        w_nib = r_disp[11:8];
        w_lz  = (r_disp[15:8] == 8'd0);
      end
      default: begin
        w_nib = r_disp[15:12];
        w_lz  = (r_disp[15:12] == 4'd0);
      end
    endcase
    if (r_ovf)                 w_seg_nxt = SEG_DASH;
    else if (blank_en && w_lz) w_seg_nxt = SEG_BLANK;
    else                       w_seg_nxt = seg_decode(w_nib);
  end

  // Display output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg_nxt;
    end
  end

  assign conv_start = r_conv_start;
  assign conv_din   = r_conv_din;
  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = 1'b1;
  assign err        = r_err;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Testbench for seg_display_ctrl, run with DIGIT_CYCLES=4, UPDATE_SCANS=2,
// CONV_TIMEOUT=8. A behavioural converter answers each conv_start after a
// fixed delay. The expected operand for each request waits in a queue until
// the DUT issues conv_start.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] d_in;
  logic        blank_en;
  logic        conv_start;
  logic [13:0] conv_din;
  logic        conv_done;
  logic [15:0] bcd_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        err;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .DIGIT_CYCLES(4),
    .UPDATE_SCANS(2),
    .CONV_TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_in      (d_in),
    .blank_en  (blank_en),
    .conv_start(conv_start),
    .conv_din  (conv_din),
    .conv_done (conv_done),
    .bcd_in    (bcd_in),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .err       (err)
  );

  typedef struct {
    int         d;
    bit         blank;
    bit         ovf;
    logic [6:0] s3, s2, s1, s0;
  } vec_t;

  int          n_assert   = 0;
  int          n_fail     = 0;
  int          cyc        = 0;
  int          pulses     = 0;
  int          last_start = 0;
  int          resp_cnt   = 0;
  bit          resp_en    = 1'b0;
  bit          resp_pulse = 1'b0;
  logic [13:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // One clock: sample #1 after the edge, score conv_start, run the converter model.
  task automatic tick();
    logic [13:0] exp_din;
    @(posedge clk);
    #1;
    cyc++;
    if (resp_pulse) begin
      conv_done  = 1'b0;
      resp_pulse = 1'b0;
    end
    if (conv_start === 1'b1) begin
      pulses++;
      last_start = cyc;
      if (resp_en) resp_cnt = 3;
      if (sb.size() > 0) begin
        exp_din = sb.pop_front();
        check("conv_din", 32'(conv_din), 32'(exp_din));
      end
    end
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        conv_done  = 1'b1;
        bcd_in     = to_bcd(int'(d_in));
        resp_pulse = 1'b1;
      end
    end
  endtask

  task automatic wait_start(input string tag, output int t);
    int p;
    int n;
    p = pulses;
    n = 0;
    while (pulses == p && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_start_seen"}, 32'(pulses != p), 32'd1);
    t = last_start;
  endtask

  // Watch one full scan and compare the pattern shown in each digit slot.
  task automatic scan(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                      input logic [6:0] e1, input logic [6:0] e0);
    logic [7:0] obs[4];
    int bad;
    bad = 0;
    for (int k = 0; k < 4; k++) obs[k] = 8'hFF;
    repeat (16) begin
      tick();
      case (an)
        4'b1110: obs[0] = {1'b0, seg};
        4'b1101: obs[1] = {1'b0, seg};
        4'b1011: obs[2] = {1'b0, seg};
        4'b0111: obs[3] = {1'b0, seg};
        default: bad++;
      endcase
      if (dp !== 1'b1) bad++;
    end
    check({tag, "_d3"}, 32'(obs[3]), 32'({1'b0, e3}));
    check({tag, "_d2"}, 32'(obs[2]), 32'({1'b0, e2}));
    check({tag, "_d1"}, 32'(obs[1]), 32'({1'b0, e1}));
    check({tag, "_d0"}, 32'(obs[0]), 32'({1'b0, e0}));
    check({tag, "_onehot_dp"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[9];
    logic [3:0]  exp_an;
    int          first_start;
    int          t0;
    int          t1;
    int          t2;
    int          te;
    int          p;

    vecs[0] = '{1234,  1'b0, 1'b0, 7'h79, 7'h24, 7'h30, 7'h19};
    vecs[1] = '{1234,  1'b1, 1'b0, 7'h79, 7'h24, 7'h30, 7'h19};
    vecs[2] = '{11,    1'b1, 1'b0, 7'h7F, 7'h7F, 7'h79, 7'h79};
    vecs[3] = '{11,    1'b0, 1'b0, 7'h40, 7'h40, 7'h79, 7'h79};
    vecs[4] = '{0,     1'b1, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    vecs[5] = '{12000, 1'b1, 1'b1, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    vecs[6] = '{42,    1'b1, 1'b0, 7'h7F, 7'h7F, 7'h19, 7'h24};
    vecs[7] = '{9999,  1'b0, 1'b0, 7'h10, 7'h10, 7'h10, 7'h10};
    vecs[8] = '{1005,  1'b1, 1'b0, 7'h79, 7'h40, 7'h40, 7'h12};

    rst_n     = 1'b0;
    d_in      = 14'd1234;
    blank_en  = 1'b0;
    conv_done = 1'b0;
    bcd_in    = 16'h0000;

    // Reset values, then scan order and the forced first conversion
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'h0F);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_conv_start", 32'(conv_start), 32'd0);
    check("rst_conv_din", 32'(conv_din), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    sb.push_back(14'd1234);
    resp_en     = 1'b1;
    rst_n       = 1'b1;
    first_start = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp_an = ~(4'b0001 << (((t - 1) / 4) % 4));
      check($sformatf("scan_an_t%0d", t), 32'(an), 32'(exp_an));
      if (conv_start === 1'b1 && first_start == 0) first_start = t;
    end
    check("first_start_within_2", 32'(first_start >= 1 && first_start <= 2), 32'd1);
    check("first_conv_scored", 32'(sb.size()), 32'd0);

    // Table-driven display values
    for (int i = 0; i < 9; i++) begin
      d_in     = 14'(vecs[i].d);
      blank_en = vecs[i].blank;
      if (vecs[i].ovf) begin
        p = pulses;
        repeat (40) tick();
        check($sformatf("v%0d_no_start", i), 32'(pulses - p), 32'd0);
      end else begin
        sb.push_back(14'(vecs[i].d));
        wait_start($sformatf("v%0d", i), t0);
        repeat (6) tick();
        check($sformatf("v%0d_err", i), 32'(err), 32'd0);
      end
      scan($sformatf("v%0d", i), vecs[i].s3, vecs[i].s2, vecs[i].s1, vecs[i].s0);
    end

    // Converter never answers: err after 8 cycles, previous digits kept
    resp_en = 1'b0;
    d_in    = 14'd7777;
    sb.push_back(14'd7777);
    wait_start("tmo", t0);
    te = 0;
    for (int n = 0; n < 20 && te == 0; n++) begin
      tick();
      if (err === 1'b1) te = cyc;
    end
    check("tmo_latency", 32'(te - t0), 32'd8);
    scan("tmo_keep", 7'h79, 7'h40, 7'h40, 7'h12);
    check("tmo_err_sticky", 32'(err), 32'd1);

    resp_en = 1'b1;
    sb.push_back(14'd7777);
    wait_start("tmo_recover", t0);
    repeat (6) tick();
    check("tmo_err_cleared", 32'(err), 32'd0);
    scan("tmo_recover", 7'h78, 7'h78, 7'h78, 7'h78);

    // Request period: 2 scans of 4 digits of 4 cycles
    wait_start("period_a", t1);
    wait_start("period_b", t2);
    check("request_period", 32'(t2 - t1), 32'd32);

    // Reset while waiting for the converter; a late done must not latch
    resp_en = 1'b0;
    wait_start("rst_wait", t0);
    tick();
    tick();
    rst_n    = 1'b0;
    resp_cnt = 0;
    #1;
    check("rstw_an", 32'(an), 32'h0F);
    check("rstw_seg", 32'(seg), 32'h7F);
    check("rstw_conv_start", 32'(conv_start), 32'd0);
    check("rstw_conv_din", 32'(conv_din), 32'd0);
    check("rstw_err", 32'(err), 32'd0);
    check("rstw_dp", 32'(dp), 32'd1);
    conv_done = 1'b1;
    bcd_in    = 16'h8888;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    conv_done = 1'b0;
    blank_en  = 1'b0;
    scan("rstw_disp", 7'h40, 7'h40, 7'h40, 7'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Sequencer and scan controller for the 4-digit seven-segment display path.
- Periodically samples a 14-bit binary value and requests a conversion from the multi-cycle binary-to-BCD converter over a start/done handshake.
- Latches the returned 4 BCD digits and time-multiplexes them onto a common-anode display, with optional leading-zero blanking.
- Shows an overflow pattern for inputs above 9999 and flags converter timeouts.

Parameters:
- DIGIT_CYCLES, 50000, clk cycles each digit stays enabled (≥2).
- UPDATE_SCANS, 16, complete 4-digit scans between conversion requests (≥1).
- CONV_TIMEOUT, 64, max cycles waited for conv_done before error (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_in  in  14  binary value to display.
- blank_en  in  1  1 = blank leading zeros.
- conv_start  out  1  one-cycle conversion request pulse.
- conv_din  out  14  value presented to converter; held stable from REQ until next REQ.
- conv_done  in  1  converter result valid (single-cycle or level).
- bcd_in  in  16  converter result; [15:12] thousands … [3:0] ones.
- an  out  4  digit enables, active-low; an[0] = ones digit.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; held 1 (off).
- err  out  1  sticky timeout flag; cleared by next successful conversion.

Behaviour:
- Reset (async, rst_n=0):
  - an=4'b1111, seg=7'h7F, dp=1, conv_start=0, conv_din=0, err=0.
  - Display register=16'h0000, ovf=0, digit index=0, prescaler=0, scan counter=0, timeout counter=0, FSM=IDLE, pending request=1 (forces a conversion right after reset).
- Scan:
  - Prescaler counts 0..DIGIT_CYCLES-1. At terminal count, index advances 0→1→2→3→0.
  - an and seg are registered from the index and display register; first cycle after reset release gives an=4'b1110.
  - Exactly one an bit is low at any time outside reset.
- Request timer:
  - Each index wrap 3→0 increments the scan counter.
  - At UPDATE_SCANS the counter clears and pending is set.
  - Pending clears when the FSM leaves IDLE. Requests arriving while the FSM is not IDLE merge into the single pending bit (no queue).
- FSM:
  - IDLE: if pending → REQ.
  - REQ (1 cycle): sample d_in.
    - d_in > 9999: ovf←1, no conv_start, → IDLE.
    - Otherwise: conv_din←d_in, conv_start=1 this cycle, timeout counter←0, → WAIT.
  - WAIT:
    - conv_done=1: display register←bcd_in, ovf←0, err←0, → IDLE.
    - Counter reaches CONV_TIMEOUT-1 without done: err←1, display register and ovf unchanged, → IDLE.
    - If done and timeout coincide, done wins.
  - conv_done outside WAIT is ignored.
- Decode:
  - Nibbles 0–9 use the standard active-low patterns: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - Nibbles 10–15 → blank (7'h7F).
  - ovf=1 → every digit shows dash 7'h3F.
- Leading-zero blanking (blank_en=1, ovf=0):
  - Digit k (k=3..1) is blanked (7'h7F) when it and all higher digits are zero. Digit 0 is never blanked.
  - blank_en is sampled combinationally each digit slot, so a change takes effect on the next seg register update.
- Display update: a new display register value appears on seg at the next registered update (≤1 cycle after LATCH, for the currently enabled digit). There is no tearing within a digit slot beyond that one edge.
- Reset mid-operation (including WAIT): immediate return to reset values; the in-flight converter result is discarded.

Test Plan:
Bench parameters: DIGIT_CYCLES=4, UPDATE_SCANS=2, CONV_TIMEOUT=8.
- Reset/scan:
  - Stimulus: hold rst_n=0, then release.
  - Required: during reset an=1111, seg=7F. Cycle 1 an=1110. Then 1101, 1011, 0111 every 4 cycles, wrapping to 1110. conv_start pulses within 2 cycles of release.
- Normal conversion:
  - Stimulus: d_in=1234, responder returns conv_done 3 cycles after conv_start with bcd_in=16'h1234.
  - Required: conv_din=1234. Slots show an[0]:7'h19, an[1]:7'h30, an[2]:7'h24, an[3]:7'h79. err=0.
- Blanking:
  - Stimulus: d_in=11 (bcd 16'h0011); compare blank_en=1 against blank_en=0.
  - Required: blank_en=1 → digits 3,2 =7'h7F, digits 1,0 =7'h79. blank_en=0 → digits 3,2 =7'h40. Also d_in=0 with blank_en=1 → only digit 0 lit, 7'h40.
- Overflow:
  - Stimulus: d_in=12000.
  - Required: no conv_start; all digits 7'h3F. Then d_in=42 → next request converts, dashes clear.
- Timeout:
  - Stimulus: responder never asserts conv_done.
  - Required: err=1 exactly 8 cycles after conv_start, prior digits retained. Next successful done clears err.
- Periodic/async reset:
  - Stimulus: count conv_start pulses; separately assert rst_n=0 during WAIT.
  - Required: one pulse per 2 full scans (32 cycles). Reset in WAIT → all outputs to reset values immediately; a late conv_done does not latch.
